// File: rtl/enemy_formation.sv
// enemy_formation: ROWS x COLS invader grid controller.
// Owns origin, alive bitmap, march/drop FSM, hit resolution and sprite lookup.
module enemy_formation #(
  parameter int ROWS        = 3,
  parameter int COLS        = 7,
  parameter int CELL_W      = 73,
  parameter int CELL_H      = 50,
  parameter int SPR_W       = 49,
  parameter int SPR_H       = 44,
  parameter int SCREEN_W    = 640,
  parameter int FLOOR_Y     = 355,
  parameter int STEP_X      = 1,
  parameter int DROP_Y      = 8,
  parameter int SPEED_SHIFT = 2,
  localparam int N  = ROWS * COLS,
  localparam int IW = $clog2(N + 1),
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          frame_tick,
  input  logic [9:0]    DrawX,
  input  logic [9:0]    DrawY,
  input  logic          hit_valid,
  input  logic [9:0]    hit_x,
  input  logic [9:0]    hit_y,
  output logic          enemy_on,
  output logic [RW-1:0] enemy_row,
  output logic [CW-1:0] enemy_col,
  output logic [5:0]    spr_x,
  output logic [5:0]    spr_y,
  output logic          hit_ack,
  output logic          hit_kill,
  output logic [RW-1:0] hit_row,
  output logic [CW-1:0] hit_col,
  output logic [IW-1:0] alive_count,
  output logic [9:0]    origin_x,
  output logic [9:0]    origin_y,
  output logic          lost,
  output logic          cleared
);

  localparam int CTW = $clog2(N + 2);
  localparam logic [10:0] CELL_W11  = 11'(CELL_W);
  localparam logic [10:0] CELL_H11  = 11'(CELL_H);
  localparam logic [10:0] SPR_W11   = 11'(SPR_W);
  localparam logic [10:0] SPR_H11   = 11'(SPR_H);
  localparam logic [10:0] SCR_MAX11 = 11'(SCREEN_W - 1);
  localparam logic [10:0] FLOOR11   = 11'(FLOOR_Y);
  localparam logic [10:0] STEP_X11  = 11'(STEP_X);
  localparam logic [10:0] DROP_Y11  = 11'(DROP_Y);
  localparam logic [9:0]  STEP_X10  = 10'(STEP_X);
  localparam logic [9:0]  DROP_Y10  = 10'(DROP_Y);
  localparam logic [CTW-1:0] INIT_IVL = CTW'((N >> SPEED_SHIFT) + 1);

  typedef enum logic [2:0] {IDLE, MARCH, DROP, LOST, CLEARED} state_t;

  state_t          state, state_nx;
  logic [N-1:0]    alive;
  logic [9:0]      ox, oy, ox_nx, oy_nx;
  logic            dir_r, dir_nx;
  logic [CTW-1:0]  cnt, cnt_nx, ivl;
  logic            init, in_play, kill;
  logic [IW-1:0]   pop;
  logic [COLS-1:0] col_live;
  logic [ROWS-1:0] row_live;
  logic [10:0]     min_col, max_col, max_row;
  logic [10:0]     bnd_l, bnd_r, bnd_b;
  logic [10:0]     cx, cy;
  logic            h_match, h_live;
  logic [RW-1:0]   h_row, p_row;
  logic [CW-1:0]   h_col, p_col;
  logic [N-1:0]    h_mask;
  logic            p_match;
  logic [5:0]      p_sx, p_sy;

  function automatic logic box(input logic [9:0] x, y,
                               input logic [10:0] bx, by);
    return ({1'b0, x} >= bx) && ({1'b0, x} <= bx + SPR_W11 - 11'd1) &&
           ({1'b0, y} >= by) && ({1'b0, y} <= by + SPR_H11 - 11'd1);
  endfunction

  assign in_play     = (state == MARCH) || (state == DROP);
  assign kill        = hit_valid && h_match && h_live && in_play;
  assign ivl         = CTW'(pop >> SPEED_SHIFT) + CTW'(1);
  assign alive_count = pop;
  assign origin_x    = ox;
  assign origin_y    = oy;
  assign lost        = (state == LOST);
  assign cleared     = (state == CLEARED);

  // live cell population
  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + IW'(alive[i]);
  end

  // bounding box of the cells that are still alive
  always_comb begin
    col_live = '0;
    row_live = '0;
    min_col  = '0;
    max_col  = '0;
    max_row  = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (alive[r*COLS+c]) begin
          col_live[c] = 1'b1;
          row_live[r] = 1'b1;
        end
    for (int c = COLS - 1; c >= 0; c--)
      if (col_live[c]) min_col = 11'(c);
    for (int c = 0; c < COLS; c++)
      if (col_live[c]) max_col = 11'(c);
    for (int r = 0; r < ROWS; r++)
      if (row_live[r]) max_row = 11'(r);
    bnd_l = {1'b0, ox} + min_col * CELL_W11;
    bnd_r = {1'b0, ox} + max_col * CELL_W11 + SPR_W11 - 11'd1;
    bnd_b = {1'b0, oy} + max_row * CELL_H11 + SPR_H11 - 11'd1;
  end

  // parallel box compare; descending scan lets the lowest index win
  always_comb begin
    h_match = 1'b0;
    h_live  = 1'b0;
    h_row   = '0;
    h_col   = '0;
    h_mask  = '0;
    p_match = 1'b0;
    p_row   = '0;
    p_col   = '0;
    p_sx    = '0;
    p_sy    = '0;
    cx      = '0;
    cy      = '0;
    for (int r = ROWS - 1; r >= 0; r--)
      for (int c = COLS - 1; c >= 0; c--) begin
        cx = {1'b0, ox} + 11'(c) * CELL_W11;
        cy = {1'b0, oy} + 11'(r) * CELL_H11;
        if (box(hit_x, hit_y, cx, cy)) begin
          h_match = 1'b1;
          h_live  = alive[r*COLS+c];
          h_row   = RW'(r);
          h_col   = CW'(c);
          h_mask  = N'(1) << (r*COLS+c);
        end
        if (alive[r*COLS+c] && box(DrawX, DrawY, cx, cy)) begin
          p_match = 1'b1;
          p_row   = RW'(r);
          p_col   = CW'(c);
          p_sx    = 6'({1'b0, DrawX} - cx);
          p_sy    = 6'({1'b0, DrawY} - cy);
        end
      end
  end

  // next state, origin, direction and frame counter
  always_comb begin
    state_nx = state;
    ox_nx    = ox;
    oy_nx    = oy;
    dir_nx   = dir_r;
    cnt_nx   = cnt;
    init     = 1'b0;
    unique case (state)
      IDLE, LOST, CLEARED: begin
        if (Start) begin
          state_nx = MARCH;
          init     = 1'b1;
        end
      end
      MARCH, DROP: begin
        if (pop == '0) begin
          state_nx = CLEARED;
        end else if (frame_tick) begin
          if (cnt != '0) begin
            cnt_nx = cnt - CTW'(1);
          end else begin
            cnt_nx = ivl - CTW'(1);
            if (state == MARCH) begin
              if (dir_r) begin
                if (bnd_r + STEP_X11 > SCR_MAX11) state_nx = DROP;
                else ox_nx = ox + STEP_X10;
              end else begin
                if (bnd_l < STEP_X11) state_nx = DROP;
                else ox_nx = ox - STEP_X10;
              end
            end else begin
              oy_nx    = oy + DROP_Y10;
              dir_nx   = ~dir_r;
              state_nx = (bnd_b + DROP_Y11 >= FLOOR11) ? LOST : MARCH;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
    if (init) begin
      ox_nx  = '0;
      oy_nx  = '0;
      dir_nx = 1'b1;
      cnt_nx = INIT_IVL;
    end
  end

  // state, origin, direction and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
      ox    <= '0;
      oy    <= '0;
      dir_r <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      ox    <= ox_nx;
      oy    <= oy_nx;
      dir_r <= dir_nx;
      cnt   <= cnt_nx;
    end
  end

  // alive bitmap: refilled on wave start, cleared by kills
  always_ff @(posedge Clk) begin
    if (Reset || init) alive <= '1;
    else if (kill)     alive <= alive & ~h_mask;
  end

  // one-cycle hit response
  always_ff @(posedge Clk) begin
    if (Reset) begin
      hit_ack  <= 1'b0;
      hit_kill <= 1'b0;
      hit_row  <= '0;
      hit_col  <= '0;
    end else begin
      hit_ack  <= hit_valid;
      hit_kill <= kill;
      hit_row  <= kill ? h_row : '0;
      hit_col  <= kill ? h_col : '0;
    end
  end

  // registered pixel lookup for the colour mapper
  always_ff @(posedge Clk) begin
    if (Reset) begin
      enemy_on  <= 1'b0;
      enemy_row <= '0;
      enemy_col <= '0;
      spr_x     <= '0;
      spr_y     <= '0;
    end else begin
      enemy_on  <= p_match;
      enemy_row <= p_row;
      enemy_col <= p_col;
      spr_x     <= p_sx;
      spr_y     <= p_sy;
    end
  end

endmodule

// File: tb/tb_enemy_formation.sv
// tb_enemy_formation: directed and random stimulus for enemy_formation,
// checked every cycle against a cell-arithmetic reference model.
module tb_enemy_formation;

  localparam int ROWS  = 3;
  localparam int COLS  = 7;
  localparam int N     = 21;
  localparam int CW    = 73;
  localparam int CH    = 50;
  localparam int SW    = 49;
  localparam int SH    = 44;
  localparam int SCRW  = 640;
  localparam int FLOOR = 355;
  localparam int STEP  = 1;
  localparam int DROPY = 8;
  localparam int SS    = 2;

  localparam int M_IDLE  = 0;
  localparam int M_MARCH = 1;
  localparam int M_DROP  = 2;
  localparam int M_LOST  = 3;
  localparam int M_CLR   = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic       frame_tick = 1'b0;
  logic       hit_valid = 1'b0;
  logic [9:0] DrawX = '0;
  logic [9:0] DrawY = '0;
  logic [9:0] hit_x = '0;
  logic [9:0] hit_y = '0;
  logic       enemy_on;
  logic [1:0] enemy_row;
  logic [2:0] enemy_col;
  logic [5:0] spr_x, spr_y;
  logic       hit_ack, hit_kill;
  logic [1:0] hit_row;
  logic [2:0] hit_col;
  logic [4:0] alive_count;
  logic [9:0] origin_x, origin_y;
  logic       lost, cleared;

  enemy_formation dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .frame_tick(frame_tick),
    .DrawX(DrawX), .DrawY(DrawY),
    .hit_valid(hit_valid), .hit_x(hit_x), .hit_y(hit_y),
    .enemy_on(enemy_on), .enemy_row(enemy_row), .enemy_col(enemy_col),
    .spr_x(spr_x), .spr_y(spr_y),
    .hit_ack(hit_ack), .hit_kill(hit_kill),
    .hit_row(hit_row), .hit_col(hit_col),
    .alive_count(alive_count),
    .origin_x(origin_x), .origin_y(origin_y),
    .lost(lost), .cleared(cleared)
  );

  always #5 Clk = ~Clk;

  bit m_alive [N];
  int m_ox, m_oy, m_cnt, m_mode;
  bit m_right;
  int e_on, e_row, e_col, e_sx, e_sy;
  int e_ack, e_kill, e_hrow, e_hcol;
  int n_chk = 0, n_pass = 0, n_fail = 0;
  bit rand_pix = 1'b1;

  function automatic int live_count();
    int s = 0;
    foreach (m_alive[i]) s += m_alive[i];
    return s;
  endfunction

  // which cell's sprite box holds (x,y), found by division into the grid
  function automatic bit locate(input int x, input int y,
                                output int r, output int c);
    int dx = x - m_ox;
    int dy = y - m_oy;
    r = 0;
    c = 0;
    if (dx < 0 || dy < 0) return 1'b0;
    c = dx / CW;
    r = dy / CH;
    if (c >= COLS || r >= ROWS) return 1'b0;
    if (dx % CW >= SW || dy % CH >= SH) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_update();
    int hr, hc, pr, pc, ac, mnc, mxc, mxr, lft, rgt, bot;
    bit hf, pf, kill;
    if (Reset) begin
      foreach (m_alive[i]) m_alive[i] = 1'b1;
      m_ox = 0; m_oy = 0; m_right = 1'b1; m_cnt = 0; m_mode = M_IDLE;
      e_on = 0; e_row = 0; e_col = 0; e_sx = 0; e_sy = 0;
      e_ack = 0; e_kill = 0; e_hrow = 0; e_hcol = 0;
      return;
    end
    hf = locate(int'(hit_x), int'(hit_y), hr, hc);
    pf = locate(int'(DrawX), int'(DrawY), pr, pc);
    kill = hit_valid && hf && m_alive[hr*COLS+hc] &&
           (m_mode == M_MARCH || m_mode == M_DROP);
    e_ack  = int'(hit_valid);
    e_kill = int'(kill);
    e_hrow = kill ? hr : 0;
    e_hcol = kill ? hc : 0;
    if (pf && m_alive[pr*COLS+pc]) begin
      e_on = 1; e_row = pr; e_col = pc;
      e_sx = int'(DrawX) - (m_ox + pc*CW);
      e_sy = int'(DrawY) - (m_oy + pr*CH);
    end else begin
      e_on = 0; e_row = 0; e_col = 0; e_sx = 0; e_sy = 0;
    end
    ac = live_count();
    mnc = COLS; mxc = 0; mxr = 0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (m_alive[r*COLS+c]) begin
          if (c < mnc) mnc = c;
          if (c > mxc) mxc = c;
          if (r > mxr) mxr = r;
        end
    lft = m_ox + mnc*CW;
    rgt = m_ox + mxc*CW + SW - 1;
    bot = m_oy + mxr*CH + SH - 1;
    if (m_mode == M_IDLE || m_mode == M_LOST || m_mode == M_CLR) begin
      if (Start) begin
        foreach (m_alive[i]) m_alive[i] = 1'b1;
        m_ox = 0; m_oy = 0; m_right = 1'b1;
        m_cnt = (N >> SS) + 1;
        m_mode = M_MARCH;
      end
    end else if (ac == 0) begin
      m_mode = M_CLR;
    end else if (frame_tick) begin
      if (m_cnt > 0) begin
        m_cnt--;
      end else begin
        m_cnt = ac >> SS;
        if (m_mode == M_MARCH) begin
          if (m_right) begin
            if (rgt + STEP > SCRW - 1) m_mode = M_DROP;
            else m_ox += STEP;
          end else begin
            if (lft < STEP) m_mode = M_DROP;
            else m_ox -= STEP;
          end
        end else begin
          m_oy += DROPY;
          m_right = !m_right;
          m_mode = (bot + DROPY >= FLOOR) ? M_LOST : M_MARCH;
        end
      end
    end
    if (kill) m_alive[hr*COLS+hc] = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("enemy_on", enemy_on, e_on);
    chk("enemy_row", enemy_row, e_row);
    chk("enemy_col", enemy_col, e_col);
    chk("spr_x", spr_x, e_sx);
    chk("spr_y", spr_y, e_sy);
    chk("hit_ack", hit_ack, e_ack);
    chk("hit_kill", hit_kill, e_kill);
    chk("hit_row", hit_row, e_hrow);
    chk("hit_col", hit_col, e_hcol);
    chk("alive_count", alive_count, live_count());
    chk("origin_x", origin_x, m_ox);
    chk("origin_y", origin_y, m_oy);
    chk("lost", lost, m_mode == M_LOST);
    chk("cleared", cleared, m_mode == M_CLR);
  endtask

  task automatic cyc();
    if (rand_pix) begin
      DrawX = 10'($urandom_range(0, 639));
      DrawY = 10'($urandom_range(0, 399));
    end
    model_update();
    @(posedge Clk);
    #1;
    check_all();
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    cyc();
  endtask

  task automatic hit(input int x, input int y);
    hit_x = 10'(x);
    hit_y = 10'(y);
    hit_valid = 1'b1;
    cyc();
    hit_valid = 1'b0;
  endtask

  task automatic restart();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  initial begin
    int k;
    Reset = 1'b1;
    cyc();
    cyc();
    chk("rst_alive", alive_count, 21);
    chk("rst_ox", origin_x, 0);
    chk("rst_oy", origin_y, 0);
    Reset = 1'b0;
    cyc();

    Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("start_alive", alive_count, 21);

    rand_pix = 1'b0;
    DrawX = 10'd75;
    DrawY = 10'd52;
    cyc();
    chk("pix_on", enemy_on, 1);
    chk("pix_row", enemy_row, 1);
    chk("pix_col", enemy_col, 1);
    chk("pix_sx", spr_x, 2);
    chk("pix_sy", spr_y, 2);

    hit(10, 10);
    chk("hit1_ack", hit_ack, 1);
    chk("hit1_kill", hit_kill, 1);
    chk("hit1_alive", alive_count, 20);
    hit(10, 10);
    chk("hit2_ack", hit_ack, 1);
    chk("hit2_kill", hit_kill, 0);
    hit(75, 52);
    chk("hit3_row", hit_row, 1);
    chk("hit3_col", hit_col, 1);
    cyc();
    chk("pix_dead", enemy_on, 0);
    rand_pix = 1'b1;

    restart();
    repeat (6) tick();
    chk("rate_hold", origin_x, 0);
    tick();
    chk("rate_first", origin_x, 1);
    repeat (6) tick();
    chk("rate_second", origin_x, 2);

    restart();
    k = 0;
    while (m_mode != M_DROP && k < 3000) begin tick(); k++; end
    chk("wall_budget", k < 3000, 1);
    chk("wall_x", origin_x, 153);
    k = 0;
    while (m_mode != M_MARCH && k < 50) begin tick(); k++; end
    chk("drop_y", origin_y, 8);
    repeat (6) tick();
    chk("left_x", origin_x, 152);

    restart();
    hit(6*CW + 10, 10);
    hit(6*CW + 10, CH + 10);
    hit(6*CW + 10, 2*CH + 10);
    chk("col6_alive", alive_count, 18);
    k = 0;
    while (m_mode != M_DROP && k < 3000) begin tick(); k++; end
    chk("col6_budget", k < 3000, 1);
    chk("col6_x", origin_x, 226);

    restart();
    for (int i = 0; i < 2500; i++) begin
      frame_tick = 1'($urandom_range(0, 1));
      hit_valid  = ($urandom_range(0, 3) == 0);
      hit_x      = 10'($urandom_range(0, 639));
      hit_y      = 10'($urandom_range(0, 255));
      Start      = ($urandom_range(0, 63) == 0);
      cyc();
    end
    frame_tick = 1'b0;
    hit_valid  = 1'b0;
    Start      = 1'b0;

    restart();
    repeat (14) tick();
    chk("clr_ox", origin_x, 2);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        hit(2 + c*CW + 10, r*CH + 10);
    chk("clr_alive", alive_count, 0);
    cyc();
    chk("clr_flag", cleared, 1);
    repeat (10) tick();
    chk("clr_frozen", origin_x, 2);
    chk("clr_sticky", cleared, 1);

    restart();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!(r == 2 && (c == 0 || c == 6)))
          hit(c*CW + 10, r*CH + 10);
    chk("lost_alive", alive_count, 2);
    k = 0;
    frame_tick = 1'b1;
    while (m_mode != M_LOST && k < 8000) begin cyc(); k++; end
    chk("lost_budget", k < 8000, 1);
    chk("lost_flag", lost, 1);
    chk("lost_y", origin_y, 216);
    repeat (20) cyc();
    frame_tick = 1'b0;
    chk("lost_frozen", origin_y, 216);
    chk("lost_sticky", lost, 1);

    restart();
    repeat (20) tick();
    Reset = 1'b1;
    cyc();
    Reset = 1'b0;
    chk("mid_rst_ox", origin_x, 0);
    chk("mid_rst_oy", origin_y, 0);
    chk("mid_rst_alive", alive_count, 21);
    hit(10, 10);
    chk("idle_hit_ack", hit_ack, 1);
    chk("idle_hit_kill", hit_kill, 0);
    repeat (4) tick();
    chk("idle_still", origin_x, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
